serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial, LSB-first subtractor computing diff = a - b - bin over WIDTH clock cycles, using one full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's combinational full-adder cell and is intended for area-constrained arithmetic datapaths. It accepts operands on a start strobe and reports the result with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse; diff/bout valid from this cycle on
diff  output  WIDTH  a - b - bin modulo 2^WIDTH
bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: the clock edge with rst=1 forces state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, operand and borrow registers=0. Reset takes priority over every other event.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, capture a, b and bin (bin goes into the borrow register), clear the counter and diff, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle the cell consumes a_reg[0], b_reg[0] and br:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - diff shifts right with d entering at the MSB.
  - a_reg and b_reg shift right.
  - The counter increments.
  - After the WIDTH-th bit, go to DONE and load bout with br_next.
- DONE: done=1 and busy=0 for exactly one cycle.
  - If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back operation) and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge 0 -> busy high for cycles 1..WIDTH -> done high in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- diff and bout hold their last result in IDLE until the next accepted start.
- diff is not meaningful while busy=1; it holds a partial shift value.
- start while in SHIFT is ignored. Operand inputs may change freely after capture.
- Counter width is clog2(WIDTH+1).
- Reset mid-operation aborts the operation: all outputs are zero on the next cycle and no done pulse is produced.

Decomposition:
- Shared include file serial_arith_defs.vh holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - default WIDTH
- Encoding 2'd3 is illegal and recovers to IDLE.
- Sub-module full_subtractor: purely combinational, ports a, b, bin, diff, bout; it is the mirror of the full-adder cell. Exactly one instance is used.

Test Plan:
1. rst high for 2 cycles -> busy=0, done=0, diff=8'h00, bout=0; start held low afterward -> outputs unchanged.
2. a=200, b=55, bin=0, start pulse -> busy high for cycles 1-8, done in cycle 9, diff=145, bout=0.
3. a=5, b=10, bin=0 -> diff=8'hFB, bout=1. Also a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Also a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
4. start with a=9, b=4, then start re-pulsed in cycle 3 with a=1, b=2 -> second request ignored; diff=5, bout=0, single done pulse.
5. start held high continuously with a=100, b=1 -> done every 9 cycles, diff=99 each time, no cycles lost between operations.
6. rst asserted in cycle 4 of an operation -> all outputs zero next cycle and no done pulse; a following start with a=3, b=3, bin=0 -> diff=0, bout=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encodings
// and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: diff = a - b - bin with borrow-out.
// Mirror of the full-adder cell used by the serial adder.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles using a
// single full-subtractor cell and a borrow flip-flop.
//
// state    | meaning
// ST_IDLE  | waiting for start; diff/bout hold the last result
// ST_SHIFT | one operand bit per cycle through the cell (busy=1)
// ST_DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state,    state_nx;
    logic [WIDTH-1:0] a_reg,    a_nx;
    logic [WIDTH-1:0] b_reg,    b_nx;
    logic [WIDTH-1:0] diff_reg, diff_nx;
    logic [CW-1:0]    cnt,      cnt_nx;
    logic             br,       br_nx;
    logic             bout_reg, bout_nx;

    logic cell_d;
    logic cell_b;

    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br),
        .diff (cell_d),
        .bout (cell_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            bout_reg <= 1'b0;
        end else begin
            state    <= state_nx;
            a_reg    <= a_nx;
            b_reg    <= b_nx;
            diff_reg <= diff_nx;
            cnt      <= cnt_nx;
            br       <= br_nx;
            bout_reg <= bout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_reg;
        b_nx     = b_reg;
        diff_nx  = diff_reg;
        cnt_nx   = cnt;
        br_nx    = br;
        bout_nx  = bout_reg;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_nx     = a;
                    b_nx     = b;
                    br_nx    = bin;
                    cnt_nx   = '0;
                    diff_nx  = '0;
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                diff_nx = {cell_d, diff_reg[WIDTH-1:1]};
                a_nx    = a_reg >> 1;
                b_nx    = b_reg >> 1;
                br_nx   = cell_b;
                cnt_nx  = cnt + CW'(1);
                if (cnt == LAST_BIT) begin
                    bout_nx  = cell_b;
                    state_nx = ST_DONE;
                end
            end
            // Unused encoding 2'd3 falls back to idle.
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, hand-built
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vbin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    vec_t vecs[5];

    // Reference: plain (W+1)-bit arithmetic; the top bit is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return (W+1)'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one start pulse, wait for done (bounded) and return what was seen.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output logic [W-1:0] od, output logic ob,
                         output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        bin   = ibin;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        bin    = 1'($urandom);
        lat    = 0;
        busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
        end
        od = diff;
        ob = bout;
    endtask

    initial begin
        logic [W-1:0] d;
        logic         bo;
        logic [W:0]   m;
        int           lat;
        int           bn;
        int           done_n;
        int           done_at[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        vecs[0] = '{8'd200, 8'd55,  1'b0, 8'd145,  1'b0};
        vecs[1] = '{8'd5,   8'd10,  1'b0, 8'hFB,   1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF,   1'b1};
        vecs[3] = '{8'h80,  8'h7F,  1'b1, 8'h00,   1'b0};
        vecs[4] = '{8'hFF,  8'hFF,  1'b0, 8'h00,   1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        // Reset state and quiet idle afterwards
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_diff", 32'(diff), 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, d, bo, lat, bn);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd9);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'd8);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].exp_diff));
            chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].exp_bout));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_hold_diff", i), 32'(diff), 32'(vecs[i].exp_diff));
            chk($sformatf("vec%0d_hold_bout", i), 32'(bout), 32'(vecs[i].exp_bout));
        end

        // start re-pulsed during SHIFT is ignored
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd4; bin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        done_n = 0;
        lat    = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1; a = 8'd1; b = 8'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_n++;
                if (lat == 0) begin
                    lat = k;
                    d   = diff;
                    bo  = bout;
                end
            end
        end
        chk("ignore_done_count", 32'(done_n), 32'd1);
        chk("ignore_lat", 32'(lat), 32'd9);
        chk("ignore_diff", 32'(d), 32'd5);
        chk("ignore_bout", 32'(bo), 32'd0);

        // start held high: back-to-back operations with no lost cycles
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd1; bin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(k);
                chk($sformatf("b2b_diff_c%0d", k), 32'(diff), 32'd99);
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            chk("b2b_done0", 32'(done_at[0]), 32'd9);
            chk("b2b_done1", 32'(done_at[1]), 32'd18);
            chk("b2b_done2", 32'(done_at[2]), 32'd27);
        end
        repeat (12) @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        start = 1'b1; a = 8'd0; b = 8'd1; bin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        do_op(8'd3, 8'd3, 1'b0, d, bo, lat, bn);
        chk("post_abort_lat", 32'(lat), 32'd9);
        chk("post_abort_diff", 32'(d), 32'd0);
        chk("post_abort_bout", 32'(bo), 32'd0);

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            if (n % 8 == 0) rb = ra;
            m = ref_sub(ra, rb, rbin);
            do_op(ra, rb, rbin, d, bo, lat, bn);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd9);
            chk($sformatf("rnd%0d_diff", n), 32'(d), 32'(m[W-1:0]));
            chk($sformatf("rnd%0d_bout", n), 32'(bo), 32'(m[W]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
